// File: rtl/requant_shift.sv
// Per-lane requantizer: rounded arithmetic right shift then saturation to a narrow signed lane.
// Two-stage pipeline with a shadowed shift amount that only swaps in while the pipeline is empty.
module requant_shift #(
  parameter int unsigned BUS_NUM          = 16,
  parameter int unsigned IN_DATA_WIDTH    = 24,
  parameter int unsigned SCALA_POS_WIDTH  = 5,
  parameter int unsigned FIXED_DATA_WIDTH = 8,
  parameter int unsigned SAT_CNT_WIDTH    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_scala_pos_vld,
  input  logic [SCALA_POS_WIDTH-1:0]            cfg_scala_pos,
  output logic                                  cfg_pending,
  input  logic [BUS_NUM*IN_DATA_WIDTH-1:0]      in_acc_data,
  input  logic [BUS_NUM-1:0]                    in_acc_data_vld,
  output logic [BUS_NUM*FIXED_DATA_WIDTH-1:0]   out_fixed_data,
  output logic [BUS_NUM-1:0]                    out_fixed_data_vld,
  output logic [SAT_CNT_WIDTH-1:0]              sat_cnt,
  input  logic                                  sat_cnt_clr
);

  // One extra bit so the rounding add cannot overflow.
  localparam int unsigned EW   = IN_DATA_WIDTH + 1;
  localparam int unsigned IncW = $clog2(BUS_NUM + 1);
  localparam logic [SCALA_POS_WIDTH-1:0] MaxShift = SCALA_POS_WIDTH'(IN_DATA_WIDTH - 1);
  localparam logic signed [EW-1:0] SatMax = EW'((1 << (FIXED_DATA_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] SatMin = ~SatMax;

  typedef enum logic [0:0] {StIdle, StPend} cfg_state_e;

  cfg_state_e                 state_q, state_d;
  logic [SCALA_POS_WIDTH-1:0] active_q, active_d, shadow_q, shadow_d, cfg_clamped;
  logic                       pipe_empty;

  logic signed [EW-1:0] s1_calc   [BUS_NUM];
  logic signed [EW-1:0] s1_data_q [BUS_NUM];
  logic [BUS_NUM-1:0]   s1_vld_q;

  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] sat_data;
  logic [BUS_NUM-1:0]                  sat_flag;
  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] out_data_q;
  logic [BUS_NUM-1:0]                  out_vld_q, sat_q;

  logic [IncW-1:0]          sat_inc;
  logic [SAT_CNT_WIDTH:0]   sat_sum;
  logic [SAT_CNT_WIDTH-1:0] sat_cnt_q, sat_cnt_d;

  // Stage 1: round half toward +inf, then arithmetic shift.
  always_comb begin
    logic signed [EW-1:0] xe;
    logic signed [EW-1:0] half;
    for (int i = 0; i < BUS_NUM; i++) begin
      xe   = EW'(signed'(in_acc_data[i*IN_DATA_WIDTH +: IN_DATA_WIDTH]));
      half = (active_q == '0) ? '0 : (EW'(1) << (active_q - 1'b1));
      s1_calc[i] = (xe + half) >>> active_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= '0;
      for (int i = 0; i < BUS_NUM; i++) s1_data_q[i] <= '0;
    end else begin
      s1_vld_q <= in_acc_data_vld;
      for (int i = 0; i < BUS_NUM; i++) begin
        if (in_acc_data_vld[i]) s1_data_q[i] <= s1_calc[i];
      end
    end
  end

  // Stage 2: clamp to the output range and flag clamped lanes.
  always_comb begin
    sat_data = '0;
    sat_flag = '0;
    for (int i = 0; i < BUS_NUM; i++) begin
      if (s1_data_q[i] > SatMax) begin
        sat_data[i*FIXED_DATA_WIDTH +: FIXED_DATA_WIDTH] = SatMax[FIXED_DATA_WIDTH-1:0];
        sat_flag[i] = 1'b1;
      end else if (s1_data_q[i] < SatMin) begin
        sat_data[i*FIXED_DATA_WIDTH +: FIXED_DATA_WIDTH] = SatMin[FIXED_DATA_WIDTH-1:0];
        sat_flag[i] = 1'b1;
      end else begin
        sat_data[i*FIXED_DATA_WIDTH +: FIXED_DATA_WIDTH] = s1_data_q[i][FIXED_DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q <= '0;
      out_vld_q  <= '0;
      sat_q      <= '0;
    end else begin
      out_vld_q <= s1_vld_q;
      for (int i = 0; i < BUS_NUM; i++) begin
        if (s1_vld_q[i]) begin
          out_data_q[i*FIXED_DATA_WIDTH +: FIXED_DATA_WIDTH] <=
              sat_data[i*FIXED_DATA_WIDTH +: FIXED_DATA_WIDTH];
          sat_q[i] <= sat_flag[i];
        end
      end
    end
  end

  assign out_fixed_data     = out_data_q;
  assign out_fixed_data_vld = out_vld_q;

  // Saturation counter: sticky at all-ones, clear keeps this cycle's increment.
  always_comb begin
    sat_inc = '0;
    for (int i = 0; i < BUS_NUM; i++) sat_inc = sat_inc + IncW'(out_vld_q[i] & sat_q[i]);
    sat_sum = {1'b0, sat_cnt_q} + (SAT_CNT_WIDTH + 1)'(sat_inc);
    if (sat_cnt_clr) begin
      sat_cnt_d = SAT_CNT_WIDTH'(sat_inc);
    end else if (sat_sum[SAT_CNT_WIDTH]) begin
      sat_cnt_d = '1;
    end else begin
      sat_cnt_d = sat_sum[SAT_CNT_WIDTH-1:0];
    end
  end

  assign sat_cnt = sat_cnt_q;

  // Config FSM: a new shift only takes effect on a cycle with nothing in flight.
  assign pipe_empty  = ~|in_acc_data_vld & ~|s1_vld_q & ~|out_vld_q;
  assign cfg_clamped = (cfg_scala_pos > MaxShift) ? MaxShift : cfg_scala_pos;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    shadow_d = shadow_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_scala_pos_vld) begin
          shadow_d = cfg_clamped;
          if (pipe_empty) active_d = cfg_clamped;
          else            state_d  = StPend;
        end
      end
      StPend: begin
        if (cfg_scala_pos_vld) shadow_d = cfg_clamped;
        if (pipe_empty) begin
          active_d = shadow_q;
          // A strobe on the swap cycle stays pending and is applied on a later empty cycle.
          if (!cfg_scala_pos_vld) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cfg_pending = (state_q == StPend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      active_q  <= '0;
      shadow_q  <= '0;
      sat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

endmodule
